prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 131 +++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Streams big-endian byte pairs into program memory and holds
//               the CPU in reset until a valid program has been loaded.
//               Define INSTR_CHECK_EN to flag illegal opcodes on err.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          pm_we,
    output logic [AW-1:0] pm_addr,
    output logic [15:0]   pm_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [AW:0]   len_q,    len_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [15:0]   wdata_q,  wdata_d;
    logic          loaded_q, loaded_d;
    logic          err_q,    err_d;
    logic [AW:0]   w_next_cnt;
    logic          w_bad_op;

    // Words written so far equals the next address; the carry bit marks a full wrap.
    assign w_next_cnt = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};

`ifdef INSTR_CHECK_EN
    assign w_bad_op = (wdata_q[15:10] == 6'b000111) || (wdata_q[15:12] == 4'b0001 && 1'b0)
                      || (wdata_q[15:14] == 2'b01);
`else
    assign w_bad_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    addr_d   = '0;
                    err_d    = 1'b0;
                    // A new load overwrites memory, so the old program is no longer valid.
                    loaded_d = 1'b0;
                    state_d  = (len == '0) ? S_DONE : S_HI;
                end
            end
            S_HI: begin
                if (rx_valid) begin
                    wdata_d[15:8] = rx_data;
                    state_d       = S_LO;
                end
            end
            S_LO: begin
                if (rx_valid) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
                if (w_bad_op) begin
                    err_d = 1'b1;
                end
                state_d = (w_next_cnt == len_q || w_next_cnt[AW]) ? S_DONE : S_HI;
            end
            S_DONE: begin
                if (!err_q) begin
                    loaded_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = (state_q == S_HI) || (state_q == S_LO);
        pm_we     = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        cpu_reset = !loaded_q || (state_q != S_IDLE);
    end

    assign pm_addr  = addr_q;
    assign pm_wdata = wdata_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomized self-checking bench for prog_loader against a
//               word-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW = 10;
`ifdef INSTR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_loader #(.AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .pm_we    (pm_we),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int            total = 0;
    int            bad   = 0;
    int            done_cnt;
    int            busy_low;
    logic [AW-1:0] wr_addr[$];
    logic [15:0]   wr_data[$];
    logic [15:0]   wbuf[$];

    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            wr_addr.push_back(pm_addr);
            wr_data.push_back(pm_wdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    // Opcode legality from its numeric value: 7, or anything in 16..31.
    function automatic bit illegal(input logic [15:0] w);
        int op;
        op = int'(w) / 1024;
        return CHECK_EN && (op == 7 || (op >= 16 && op <= 31));
    endfunction

    function automatic bit any_illegal();
        bit r = 1'b0;
        foreach (wbuf[i]) r |= illegal(wbuf[i]);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int stall);
        repeat (stall) begin
            rx_valid = 1'b0;
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 64 && rx_ready !== 1'b1; n++) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
        if (rx_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL rx_ready_timeout: got %b required 1", rx_ready);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic start_load(input int L);
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        busy_low = 0;
        start = 1'b1;
        len   = L[AW:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input int smin, input int smax);
        foreach (wbuf[i]) begin
            send_byte(wbuf[i][15:8], int'($urandom_range(smax, smin)));
            send_byte(wbuf[i][7:0],  int'($urandom_range(smax, smin)));
        end
    endtask

    task automatic wait_done();
        for (int n = 0; n < 16 && done !== 1'b1; n++) @(negedge clk);
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done_timeout: got %b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset: got %b required 1", cpu_reset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready: got %b required 0", rx_ready); end
        total++; if (pm_we !== 1'b0) begin bad++; $display("FAIL rst_pm_we: got %b required 0", pm_we); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_done_err: got %b%b required 00", done, err); end
        total++; if (pm_addr !== '0 || pm_wdata !== '0) begin bad++; $display("FAIL rst_addr_data: got %h/%h required 0/0", pm_addr, pm_wdata); end
    endtask

    task automatic test_basic();
        wbuf = '{16'h0805, 16'h1403};
        start_load(2);
        send_words(0, 0);
        wait_done();
        total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL basic_wcount: got %0d required 2", wr_addr.size()); end
        foreach (wbuf[i]) begin
            logic [AW-1:0] a; logic [15:0] d;
            a = (i < wr_addr.size()) ? wr_addr[i] : 'x;
            d = (i < wr_data.size()) ? wr_data[i] : 'x;
            total++;
            if (a !== AW'(i) || d !== wbuf[i]) begin
                bad++; $display("FAIL basic_write%0d: got %h@%h required %h@%h", i, d, a, wbuf[i], AW'(i));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL basic_cpu_reset: got %b required 0", cpu_reset); end
    endtask

    task automatic test_stall();
        wbuf = '{16'hA123};
        start_load(1);
        send_words(7, 7);
        repeat (8) @(negedge clk);
        total++; if (wr_addr.size() != 1 || wr_data[0] !== 16'hA123 || wr_addr[0] !== '0) begin
            bad++; $display("FAIL stall_write: got %0d writes first %h required 1 write A123@0", wr_addr.size(), wr_data.size() > 0 ? wr_data[0] : 16'hxxxx);
        end
        total++; if (busy_low != 0) begin bad++; $display("FAIL stall_busy: got %0d low cycles required 0", busy_low); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_len0();
        wbuf.delete();
        start_load(0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done_next: got %b required 1", done); end
        wait_done();
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL len0_writes: got %0d required 0", wr_addr.size()); end
        total++; if (cpu_reset !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL len0_loaded: got cpu_reset=%b busy=%b required 0 0", cpu_reset, busy); end
    endtask

    task automatic test_err();
        bit exp_bad;
        wbuf = '{16'h4400};
        exp_bad = any_illegal();
        start_load(1);
        send_words(0, 2);
        wait_done();
        total++; if (wr_addr.size() != 1 || wr_data[0] !== 16'h4400) begin bad++; $display("FAIL err_write: got %0d writes required 1 of 4400", wr_addr.size()); end
        total++; if (err !== exp_bad) begin bad++; $display("FAIL err_flag: got %b required %b", err, exp_bad); end
        total++; if (cpu_reset !== exp_bad) begin bad++; $display("FAIL err_cpu_reset: got %b required %b", cpu_reset, exp_bad); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL err_done: got %0d pulses required 1", done_cnt); end
        wbuf = '{16'h0805};
        start_load(1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start: got %b required 0", err); end
        send_words(0, 1);
        wait_done();
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL err_reload_cpu_reset: got %b required 0", cpu_reset); end
    endtask

    task automatic test_reset_midload();
        start_load(3);
        send_byte(8'hA5, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin bad++; $display("FAIL midrst_idle: got busy=%b rx_ready=%b required 0 0", busy, rx_ready); end
        total++; if (pm_wdata !== 16'h0000 || pm_addr !== '0) begin bad++; $display("FAIL midrst_regs: got %h@%h required 0000@0", pm_wdata, pm_addr); end
        rx_valid = 1'b1; rx_data = 8'h3C;
        repeat (10) @(negedge clk);
        rx_valid = 1'b0;
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL midrst_no_we: got %0d writes required 0", wr_addr.size()); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL midrst_cpu_reset: got %b required 1", cpu_reset); end
    endtask

    task automatic test_ignore_start();
        wbuf = '{16'h1234};
        start_load(1);
        start = 1'b1; len = '0;
        send_byte(8'h12, 1);
        send_byte(8'h34, 2);
        start = 1'b0;
        wait_done();
        total++; if (wr_addr.size() != 1 || wr_data[0] !== 16'h1234) begin bad++; $display("FAIL ignore_start: got %0d writes required 1 of 1234", wr_addr.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_start_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int L; int mism; bit exp_bad;
            L = int'($urandom_range(8, 1));
            wbuf.delete();
            for (int i = 0; i < L; i++) wbuf.push_back(16'($urandom));
            exp_bad = any_illegal();
            start_load(L);
            send_words(0, 3);
            wait_done();
            mism = 0;
            for (int i = 0; i < L; i++) begin
                if (i >= wr_addr.size() || wr_addr[i] !== AW'(i) || wr_data[i] !== wbuf[i]) mism++;
            end
            total++; if (wr_addr.size() != L || mism != 0) begin bad++; $display("FAIL rand%0d_writes: got %0d writes %0d wrong required %0d writes 0 wrong", t, wr_addr.size(), mism, L); end
            total++; if (err !== exp_bad || cpu_reset !== exp_bad) begin bad++; $display("FAIL rand%0d_status: got err=%b cpu_reset=%b required %b %b", t, err, cpu_reset, exp_bad, exp_bad); end
            total++; if (done_cnt != 1 || busy_low != 0) begin bad++; $display("FAIL rand%0d_handshake: got done=%0d busy_low=%0d required 1 0", t, done_cnt, busy_low); end
        end
    endtask

    task automatic test_clip();
        int mism;
        wbuf.delete();
        for (int i = 0; i < (1 << AW); i++) wbuf.push_back(16'($urandom));
        start_load((1 << AW) + 76);
        send_words(0, 0);
        wait_done();
        mism = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            if (i >= wr_addr.size() || wr_addr[i] !== AW'(i) || wr_data[i] !== wbuf[i]) mism++;
        end
        total++; if (wr_addr.size() != (1 << AW) || mism != 0) begin bad++; $display("FAIL clip_writes: got %0d writes %0d wrong required %0d 0", wr_addr.size(), mism, 1 << AW); end
        total++; if (done_cnt != 1 || busy !== 1'b0) begin bad++; $display("FAIL clip_done: got done=%0d busy=%b required 1 0", done_cnt, busy); end
        total++; if (pm_addr !== '0) begin bad++; $display("FAIL clip_wrap: got %h required 0", pm_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_err();
        test_reset_midload();
        test_ignore_start();
        test_random();
        test_clip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
